// File: rtl/uart_rx_if.sv
// Byte delivery handshake for the UART receiver.
// Carries rx_data/rx_data_valid to the consumer, rx_data_ready back.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;

  modport master (
    output rx_data,
    output rx_data_valid,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, counter-oversampled, one-entry holding register.
// Ports: clk_50m, rst (sync, high), rx_pin, rx_if (data/valid/ready),
// rx_frame_err and rx_overrun one-cycle pulses.
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic     clk_50m,
  input  logic     rst,
  input  logic     rx_pin,
  uart_rx_if.master rx_if,
  output logic     rx_frame_err,
  output logic     rx_overrun
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] C_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] C_MID  = 16'(CYCLE / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_REC_BYTE,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_fe;
  logic        r_ov;
  logic        w_fall;
  logic        w_line;
  logic        w_mid;
  logic        w_last;
  logic        w_stop_smp;

  assign w_fall     = r_sync3 & ~r_sync2;
  assign w_line     = r_sync2;
  assign w_mid      = (r_cycle_cnt == C_MID);
  assign w_last     = (r_cycle_cnt == C_LAST);
  assign w_stop_smp = (r_state == S_STOP) && w_mid;

  // Line idles high, so sync flops reset high to avoid a false edge.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_START;
      end
      S_START: begin
        if (w_mid && w_line) w_next = S_IDLE;
        else if (w_last)     w_next = S_REC_BYTE;
      end
      S_REC_BYTE: begin
        if (w_last && (r_bit_cnt == 3'd7))
          w_next = S_STOP;
      end
      S_STOP: begin
        // Leave at mid stop bit: half a bit of slack for the next start.
        if (w_mid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst)
      r_cycle_cnt <= '0;
    else if (r_state != w_next)
      r_cycle_cnt <= '0;
    else if ((r_state == S_REC_BYTE) && w_last)
      r_cycle_cnt <= '0;
    else
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
  end

  always_ff @(posedge clk_50m) begin
    if (rst)
      r_bit_cnt <= '0;
    else if (r_state != S_REC_BYTE)
      r_bit_cnt <= '0;
    else if (w_last)
      r_bit_cnt <= r_bit_cnt + 3'd1;
  end

  always_ff @(posedge clk_50m) begin
    if (rst)
      r_shift <= '0;
    else if ((r_state == S_REC_BYTE) && w_mid)
      r_shift[r_bit_cnt] <= w_line;
  end

  // A new byte wins over a same-edge accept, so valid stays set.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      r_ov <= 1'b0;
      if (w_stop_smp && w_line) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ov    <= r_valid & ~rx_if.rx_data_ready;
      end else begin
        if (w_stop_smp)
          r_fe <= 1'b1;
        if (r_valid && rx_if.rx_data_ready)
          r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data       = r_data;
  assign rx_if.rx_data_valid = r_valid;
  assign rx_frame_err        = r_fe;
  assign rx_overrun          = r_ov;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 50 MHz / 115200 baud.
// Sends frames on rx_pin and checks data, handshake and error pulses.
module tb_uart_rx;

  localparam int CYC = 434;

  logic clk_50m = 1'b0;
  logic rst     = 1'b1;
  logic rx_pin  = 1'b1;
  logic fe;
  logic ov;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FRE   (50),
    .BAUD_RATE (115200)
  ) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .rx_if        (u_if.master),
    .rx_frame_err (fe),
    .rx_overrun   (ov)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int         n_hs = 0;
  int         n_fe = 0;
  int         n_ov = 0;
  int         rise_cyc = -1;
  logic       prev_v = 1'b0;
  logic [7:0] q[$];

  always @(negedge clk_50m) begin
    if (u_if.rx_data_valid && u_if.rx_data_ready) begin
      n_hs = n_hs + 1;
      q.push_back(u_if.rx_data);
    end
    if (fe) n_fe = n_fe + 1;
    if (ov) n_ov = n_ov + 1;
    if (u_if.rx_data_valid && !prev_v) rise_cyc = cyc;
    prev_v = u_if.rx_data_valid;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int t_start;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stop,
                      input int per);
    t_start = cyc;
    rx_pin = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_cyc(per);
    end
    rx_pin = stop;
    wait_cyc(per);
  endtask

  int hs0;
  int fe0;
  int ov0;
  int qi;

  initial begin
    u_if.rx_data_ready = 1'b1;
    wait_cyc(5);
    chk("rst_data", 32'(u_if.rx_data), 32'h00);
    chk("rst_valid", 32'(u_if.rx_data_valid), 32'd0);
    chk("rst_fe", 32'(fe), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    rst = 1'b0;
    wait_cyc(20);

    // single byte, latency
    hs0 = n_hs; fe0 = n_fe; ov0 = n_ov;
    send(8'hA5, 1'b1, CYC);
    wait_cyc(20);
    chk("a5_count", 32'(n_hs - hs0), 32'd1);
    chk("a5_data", 32'(q[q.size()-1]), 32'hA5);
    chk("a5_latency", 32'(rise_cyc), 32'(t_start + 4126));
    chk("a5_flags", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // back-to-back
    hs0 = n_hs; fe0 = n_fe; ov0 = n_ov;
    qi = q.size();
    send(8'h00, 1'b1, CYC);
    send(8'hFF, 1'b1, CYC);
    send(8'h55, 1'b1, CYC);
    wait_cyc(20);
    chk("b2b_count", 32'(n_hs - hs0), 32'd3);
    chk("b2b_d0", 32'(q[qi]), 32'h00);
    chk("b2b_d1", 32'(q[qi+1]), 32'hFF);
    chk("b2b_d2", 32'(q[qi+2]), 32'h55);
    chk("b2b_flags", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // overrun
    u_if.rx_data_ready = 1'b0;
    ov0 = n_ov;
    send(8'h3C, 1'b1, CYC);
    wait_cyc(20);
    chk("ovr_v1", 32'(u_if.rx_data_valid), 32'd1);
    chk("ovr_d1", 32'(u_if.rx_data), 32'h3C);
    send(8'hC3, 1'b1, CYC);
    wait_cyc(20);
    chk("ovr_v2", 32'(u_if.rx_data_valid), 32'd1);
    chk("ovr_d2", 32'(u_if.rx_data), 32'hC3);
    chk("ovr_pulse", 32'(n_ov - ov0), 32'd1);
    hs0 = n_hs;
    u_if.rx_data_ready = 1'b1;
    wait_cyc(1);
    u_if.rx_data_ready = 1'b0;
    chk("ovr_clear", 32'(u_if.rx_data_valid), 32'd0);
    chk("ovr_hs", 32'(n_hs - hs0), 32'd1);
    chk("ovr_hs_d", 32'(q[q.size()-1]), 32'hC3);
    u_if.rx_data_ready = 1'b1;
    wait_cyc(5);

    // framing error then recovery
    hs0 = n_hs; fe0 = n_fe; ov0 = n_ov;
    send(8'h81, 1'b0, CYC);
    rx_pin = 1'b1;
    wait_cyc(50);
    chk("fe_pulse", 32'(n_fe - fe0), 32'd1);
    chk("fe_nodata", 32'(n_hs - hs0), 32'd0);
    chk("fe_valid", 32'(u_if.rx_data_valid), 32'd0);
    send(8'h12, 1'b1, CYC);
    wait_cyc(20);
    chk("fe_next_cnt", 32'(n_hs - hs0), 32'd1);
    chk("fe_next_d", 32'(q[q.size()-1]), 32'h12);

    // glitch rejection
    hs0 = n_hs; fe0 = n_fe; ov0 = n_ov;
    rx_pin = 1'b0;
    wait_cyc(100);
    rx_pin = 1'b1;
    wait_cyc(2 * CYC);
    chk("gl_nodata", 32'(n_hs - hs0), 32'd0);
    chk("gl_flags", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // reset mid-byte after bit 3, then clean frame
    rx_pin = 1'b0;
    wait_cyc(5 * CYC);
    rst = 1'b1;
    rx_pin = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    chk("mr_valid", 32'(u_if.rx_data_valid), 32'd0);
    chk("mr_data", 32'(u_if.rx_data), 32'h00);
    send(8'h7E, 1'b1, CYC);
    wait_cyc(20);
    chk("mr_count", 32'(n_hs - hs0), 32'd1);
    chk("mr_d", 32'(q[q.size()-1]), 32'h7E);
    chk("mr_flags", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // baud offset +/-3 %
    hs0 = n_hs;
    send(8'h96, 1'b1, 447);
    wait_cyc(20);
    chk("fast_d", 32'(q[q.size()-1]), 32'h96);
    send(8'h96, 1'b1, 421);
    wait_cyc(20);
    chk("slow_d", 32'(q[q.size()-1]), 32'h96);
    chk("baud_count", 32'(n_hs - hs0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the board's UART transmitter: it recovers 8N1 bytes from the `rx_pin` line at the same parameterised baud rate. Each completed byte goes to the downstream consumer (sugar-reading command parser / loopback logic) through a one-entry valid/ready holding register. The block also flags framing errors and overruns. It runs entirely in the 50 MHz system clock domain and oversamples the asynchronous line with a counter, without a baud-rate clock.

## Interface
- `CLK_FRE`, 50, system clock frequency in MHz
- `BAUD_RATE`, 115200, serial baud rate; `CYCLE = CLK_FRE*1000000/BAUD_RATE` clocks per bit (434 at defaults); legal only for `CYCLE >= 8`
- `clk_50m`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx_pin`  in  1  asynchronous serial line, idle high
- `rx_data`  out  8  received byte, LSB first on the wire; stable while `rx_data_valid` = 1
- `rx_data_valid`  out  1  holding register full
- `rx_data_ready`  in  1  consumer accepts `rx_data` on any edge where valid && ready
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded
- `rx_overrun`  out  1  one-cycle pulse: new byte overwrote an unconsumed byte

## Operation
- **Input conditioning**
  - `rx_pin` passes through a 2-flop synchronizer, then a third flop.
  - Falling edge = third flop 1 && second flop 0.
  - All sampling uses the second-flop output.
- **Counters**
  - `cycle_cnt` is 16-bit. It clears on every state change and at `CYCLE-1` within `S_REC_BYTE`; otherwise it increments.
  - `bit_cnt` is 3-bit. It increments at `CYCLE-1` in `S_REC_BYTE` and clears in every other state.
- **FSM**, sample point `MID = CYCLE/2 - 1` (integer division):
  - `S_IDLE`: on a falling edge -> `S_START`.
  - `S_START`: at `cycle_cnt == MID`, line high -> `S_IDLE` (glitch rejected, no flags). At `cycle_cnt == CYCLE-1` -> `S_REC_BYTE`.
  - `S_REC_BYTE`: at `MID`, shift the sampled level into `rx_shift[bit_cnt]`. At `CYCLE-1` with `bit_cnt == 7` -> `S_STOP`.
  - `S_STOP`: at `MID`, sample the stop bit and go directly to `S_IDLE`. This leaves half a bit time for the next start edge.
- **Delivery**, on the `S_STOP` sample edge:
  - Stop bit high: `rx_data <= rx_shift` and `rx_data_valid <= 1`. If valid was already 1 and ready is 0 on that edge, pulse `rx_overrun`.
  - Stop bit low: pulse `rx_frame_err`. `rx_data` and `rx_data_valid` are unchanged.
- **Handshake**
  - Valid clears on the edge where valid && ready, unless a new byte is delivered on that same edge.
  - If both happen on the same edge, the new byte loads, valid stays 1, and there is no overrun.
- **Reset**: `rst` mid-frame aborts reception with no flags. On the first edge after `rst` deasserts, the block is in `S_IDLE`.

## Timing
- Reset values:
  - `rx_data` = 8'h00
  - `rx_data_valid` = 0
  - `rx_frame_err` = 0
  - `rx_overrun` = 0
  - state = `S_IDLE`, counters 0, synchronizer flops 1
- Pin-to-detect latency: the FSM enters `S_START` 3 clocks after the first edge that sees `rx_pin` low.
- Delivery latency: let edge k be the edge that enters `S_START`.
  - Data bit n is sampled at k + (n+1)*CYCLE + MID.
  - The stop bit is sampled, and valid/flags are updated, at k + 9*CYCLE + MID. At defaults this is k + 4122.
- Flags are high for exactly one cycle and are registered outputs.
- Back-to-back frames with a full one-bit stop are received with no gaps or loss. The tolerated baud mismatch is about ±4 %.
- A consumer that holds `rx_data_ready` = 1 sees valid high for exactly one cycle per byte.

## Test plan
- Byte 8'hA5 sent at 115200 with ready = 1 -> `rx_data` = 8'hA5, valid pulses once at k + 4122, no flags.
- Bytes 8'h00, 8'hFF, 8'h55 sent back-to-back with one stop bit, ready held high -> three valid pulses, data in order, no flags.
- 8'h3C followed by 8'hC3 with ready = 0 -> `rx_data` = 8'hC3, valid stays 1, `rx_overrun` pulses once; asserting ready for one cycle then clears valid.
- Frame 8'h81 with the stop bit forced low -> `rx_frame_err` pulses once, valid stays 0, and the next good frame 8'h12 is received correctly.
- 100-clock low glitch on an idle line -> return to `S_IDLE`, no valid, no flags. `rst` asserted mid-byte (after bit 3), then a clean frame 8'h7E -> only 8'h7E is delivered.
- Sender baud offset of +3 % and −3 % on the byte 8'h96 -> received correctly in both cases.
